// File: rtl/taxi_trip_ctrl_pkg.sv
// Shared definitions for the taxi trip controller: state encoding,
// tariff bundle type and the default day/night tariffs (all BCD).
package taxi_trip_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HIRED   = 2'd1,
    ST_WAITING = 2'd2,
    ST_SETTLE  = 2'd3
  } state_e;

  // One tariff = start fare, fare per 10 m pulse, fare per wait unit.
  typedef struct packed {
    logic [11:0] s_fare;
    logic [11:0] dist_fare;
    logic [11:0] wait_fare;
  } tariff_t;

  localparam logic [15:0] DEF_WAIT_TIMEOUT    = 16'd50000;

  localparam logic [11:0] DEF_DAY_S_FARE      = 12'h300;
  localparam logic [11:0] DEF_DAY_DIST_FARE   = 12'h003;
  localparam logic [11:0] DEF_DAY_WAIT_FARE   = 12'h050;

  localparam logic [11:0] DEF_NIGHT_S_FARE    = 12'h400;
  localparam logic [11:0] DEF_NIGHT_DIST_FARE = 12'h004;
  localparam logic [11:0] DEF_NIGHT_WAIT_FARE = 12'h070;

  // Choose the tariff bundle for a trip from the night_mode sample.
  function automatic tariff_t pick_tariff(input logic night,
                                          input tariff_t day_t,
                                          input tariff_t night_t);
    return night ? night_t : day_t;
  endfunction

endpackage

// File: rtl/taxi_trip_ctrl_pulse_sync_edge.sv
// Brings the raw distance sensor level into the clk domain and turns each
// synchronised rising edge into a registered one-cycle strobe. The strobe
// appears three clock edges after the raw edge is first sampled.
module pulse_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic pulse_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic pulse_q;
  logic pulse_d;

  assign pulse_d = sync2_q & ~prev_q;

  // Two-flop synchroniser, edge history and registered strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= async_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/taxi_trip_ctrl.sv
// Taxi trip controller: runs the trip state machine, decides when the cab
// is waiting (no distance pulses for WAIT_TIMEOUT cycles), and latches the
// day or night tariff for the fare meter at the start of each trip.
module taxi_trip_ctrl
  import taxi_trip_ctrl_pkg::*;
#(
  parameter logic [15:0] WAIT_TIMEOUT    = DEF_WAIT_TIMEOUT,
  parameter logic [11:0] DAY_S_FARE      = DEF_DAY_S_FARE,
  parameter logic [11:0] DAY_DIST_FARE   = DEF_DAY_DIST_FARE,
  parameter logic [11:0] DAY_WAIT_FARE   = DEF_DAY_WAIT_FARE,
  parameter logic [11:0] NIGHT_S_FARE    = DEF_NIGHT_S_FARE,
  parameter logic [11:0] NIGHT_DIST_FARE = DEF_NIGHT_DIST_FARE,
  parameter logic [11:0] NIGHT_WAIT_FARE = DEF_NIGHT_WAIT_FARE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_btn,
  input  logic        stop_btn,
  input  logic        pay_done,
  input  logic        night_mode,
  input  logic        ten_meter_pulse,
  output logic        en,
  output logic        wait_en,
  output logic        meter_clr,
  output logic [11:0] s_fare,
  output logic [11:0] distance_fare_per_pulse,
  output logic [11:0] wait_fare_per_unit,
  output logic        dist_pulse,
  output logic [1:0]  state
);

  localparam tariff_t DAY_TARIFF   = '{s_fare: DAY_S_FARE,
                                       dist_fare: DAY_DIST_FARE,
                                       wait_fare: DAY_WAIT_FARE};
  localparam tariff_t NIGHT_TARIFF = '{s_fare: NIGHT_S_FARE,
                                       dist_fare: NIGHT_DIST_FARE,
                                       wait_fare: NIGHT_WAIT_FARE};

  state_e      state_q;
  logic        en_q;
  logic        wait_en_q;
  logic        meter_clr_q;
  logic [15:0] idle_cnt_q;
  logic [15:0] idle_cnt_d;
  tariff_t     tariff_q;
  tariff_t     tariff_d;
  logic        dist_pulse_w;
  logic        timeout_w;
  logic        trip_start_w;

  pulse_sync_edge u_pulse_sync_edge (
    .clk     (clk),
    .rst     (rst),
    .async_i (ten_meter_pulse),
    .pulse_o (dist_pulse_w)
  );

  assign trip_start_w = (state_q == ST_IDLE) && start_btn;

  // Last quiet cycle before waiting: a distance pulse in this cycle wins.
  assign timeout_w = (idle_cnt_q >= (WAIT_TIMEOUT - 16'd1)) && !dist_pulse_w;

  // Idle counter next value: counts pulse-less cycles while hired,
  // saturates at WAIT_TIMEOUT, and rests at zero outside an active trip.
  always_comb begin
    idle_cnt_d = idle_cnt_q;
    case (state_q)
      ST_HIRED: begin
        if (dist_pulse_w) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q < WAIT_TIMEOUT) begin
          idle_cnt_d = idle_cnt_q + 16'd1;
        end
      end
      ST_WAITING: begin
        if (dist_pulse_w) begin
          idle_cnt_d = '0;
        end
      end
      default: idle_cnt_d = '0;
    endcase
  end

  // Idle counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end

  // Trip FSM with registered enables; stop beats distance beats timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      en_q        <= 1'b0;
      wait_en_q   <= 1'b0;
      meter_clr_q <= 1'b0;
    end else begin
      meter_clr_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_btn) begin
            state_q     <= ST_HIRED;
            en_q        <= 1'b1;
            wait_en_q   <= 1'b0;
            meter_clr_q <= 1'b1;
          end
        end
        ST_HIRED: begin
          if (stop_btn) begin
            state_q   <= ST_SETTLE;
            en_q      <= 1'b0;
            wait_en_q <= 1'b0;
          end else if (timeout_w) begin
            state_q   <= ST_WAITING;
            wait_en_q <= 1'b1;
          end
        end
        ST_WAITING: begin
          if (stop_btn) begin
            state_q   <= ST_SETTLE;
            en_q      <= 1'b0;
            wait_en_q <= 1'b0;
          end else if (dist_pulse_w) begin
            state_q   <= ST_HIRED;
            wait_en_q <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (pay_done) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          en_q      <= 1'b0;
          wait_en_q <= 1'b0;
        end
      endcase
    end
  end

  // Tariff chosen from night_mode only in the start cycle; held all trip.
  always_comb begin
    tariff_d = tariff_q;
    if (trip_start_w) begin
      tariff_d = pick_tariff(night_mode, DAY_TARIFF, NIGHT_TARIFF);
    end
  end

  // Tariff latch; reset falls back to the day tariff.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tariff_q <= DAY_TARIFF;
    end else begin
      tariff_q <= tariff_d;
    end
  end

  assign state                   = state_q;
  assign en                      = en_q;
  assign wait_en                 = wait_en_q;
  assign meter_clr               = meter_clr_q;
  assign dist_pulse              = dist_pulse_w;
  assign s_fare                  = tariff_q.s_fare;
  assign distance_fare_per_pulse = tariff_q.dist_fare;
  assign wait_fare_per_unit      = tariff_q.wait_fare;

endmodule

// File: tb/tb_taxi_trip_ctrl.sv
// Bench for taxi_trip_ctrl. A trip-level reference model predicts every
// change of the DUT's visible outputs (with the cycle it must appear in)
// and queues it; a monitor on the falling edge pops one expectation each
// time the DUT's outputs change and compares value and cycle.
module tb_taxi_trip_ctrl;

  localparam int WT = 8;

  localparam int P_IDLE    = 0;
  localparam int P_HIRED   = 1;
  localparam int P_WAITING = 2;
  localparam int P_SETTLE  = 3;

  typedef struct packed {
    logic [1:0]  st;
    logic        en;
    logic        we;
    logic        clr;
    logic        dp;
    logic [11:0] sf;
    logic [11:0] df;
    logic [11:0] wf;
  } snap_t;

  typedef struct {
    int    cyc;
    snap_t s;
  } ev_t;

  logic        clk;
  logic        rst;
  logic        start_btn;
  logic        stop_btn;
  logic        pay_done;
  logic        night_mode;
  logic        ten_meter_pulse;
  logic        en;
  logic        wait_en;
  logic        meter_clr;
  logic [11:0] s_fare;
  logic [11:0] distance_fare_per_pulse;
  logic [11:0] wait_fare_per_unit;
  logic        dist_pulse;
  logic [1:0]  state;

  taxi_trip_ctrl #(.WAIT_TIMEOUT(16'd8)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .start_btn               (start_btn),
    .stop_btn                (stop_btn),
    .pay_done                (pay_done),
    .night_mode              (night_mode),
    .ten_meter_pulse         (ten_meter_pulse),
    .en                      (en),
    .wait_en                 (wait_en),
    .meter_clr               (meter_clr),
    .s_fare                  (s_fare),
    .distance_fare_per_pulse (distance_fare_per_pulse),
    .wait_fare_per_unit      (wait_fare_per_unit),
    .dist_pulse              (dist_pulse),
    .state                   (state)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  ev_t exp_q[$];

  // ---------------- reference model ----------------
  int          m_phase;
  int          m_last_act;
  logic        m_raw_prev;
  int          pend_q[$];
  logic [11:0] m_sf, m_df, m_wf;
  snap_t       seen, seen_prev;
  logic        raw_lvl, night_lvl;
  bit          sync_fired;

  function automatic snap_t mk(input int ph, input logic clr, input logic dp);
    snap_t s;
    s.st  = 2'(ph);
    s.en  = (ph == P_HIRED) || (ph == P_WAITING);
    s.we  = (ph == P_WAITING);
    s.clr = clr;
    s.dp  = dp;
    s.sf  = m_sf;
    s.df  = m_df;
    s.wf  = m_wf;
    return s;
  endfunction

  task automatic load_tariff(input logic night);
    if (night) begin
      m_sf = 12'h400; m_df = 12'h004; m_wf = 12'h070;
    end else begin
      m_sf = 12'h300; m_df = 12'h003; m_wf = 12'h050;
    end
  endtask

  // Inputs of cycle n decide what is visible in cycle n+1.
  task automatic model_step(input int n, input logic st, input logic sp,
                            input logic pd, input logic ng, input logic rw);
    logic  dp_now, dp_nxt, clr_nxt;
    snap_t nxt;
    if (rw && !m_raw_prev) pend_q.push_back(n + 3);
    m_raw_prev = rw;
    dp_now = (pend_q.size() > 0) && (pend_q[0] == n);
    if (dp_now) void'(pend_q.pop_front());
    clr_nxt = 1'b0;
    case (m_phase)
      P_IDLE: if (st) begin
        m_phase = P_HIRED; clr_nxt = 1'b1; m_last_act = n; load_tariff(ng);
      end
      P_HIRED: begin
        if (sp) m_phase = P_SETTLE;
        else if (dp_now) m_last_act = n;
        else if (n - m_last_act >= WT) m_phase = P_WAITING;
      end
      P_WAITING: begin
        if (sp) m_phase = P_SETTLE;
        else if (dp_now) begin m_phase = P_HIRED; m_last_act = n; end
      end
      default: if (pd) m_phase = P_IDLE;
    endcase
    dp_nxt = (pend_q.size() > 0) && (pend_q[0] == n + 1);
    nxt = mk(m_phase, clr_nxt, dp_nxt);
    seen_prev = seen;
    if (nxt != seen) exp_q.push_back('{n + 1, nxt});
    seen = nxt;
  endtask

  // Reset asserted mid-cycle n: outputs must drop at once, within cycle n.
  task automatic model_reset(input int n);
    while (exp_q.size() > 0 && exp_q[$].cyc == n) void'(exp_q.pop_back());
    m_phase = P_IDLE;
    pend_q.delete();
    m_raw_prev = 1'b0;
    load_tariff(1'b0);
    seen = mk(P_IDLE, 1'b0, 1'b0);
    if (seen != seen_prev) exp_q.push_back('{n, seen});
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick(input logic st, input logic sp, input logic pd,
                      input bit sync_stop = 1'b0);
    logic sp_eff;
    @(posedge clk); #2;
    sync_fired = sync_stop && (pend_q.size() > 0) && (pend_q[0] == cyc);
    sp_eff = sp | sync_fired;
    rst = 1'b0;
    start_btn = st; stop_btn = sp_eff; pay_done = pd;
    night_mode = night_lvl; ten_meter_pulse = raw_lvl;
    model_step(cyc, st, sp_eff, pd, night_lvl, raw_lvl);
  endtask

  task automatic do_reset(input int hold);
    @(posedge clk); #2;
    rst = 1'b1;
    start_btn = 1'b0; stop_btn = 1'b0; pay_done = 1'b0;
    raw_lvl = 1'b0; ten_meter_pulse = 1'b0;
    model_reset(cyc);
    repeat (hold) begin
      @(posedge clk); #2;
      seen_prev = seen;
    end
  endtask

  // ---------------- monitor ----------------
  bit    mon_first = 1'b1;
  snap_t mon_prev;

  always @(negedge clk) begin : monitor
    snap_t s;
    ev_t   e;
    s = '{state, en, wait_en, meter_clr, dist_pulse, s_fare,
          distance_fare_per_pulse, wait_fare_per_unit};
    if (mon_first || s != mon_prev) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL extra_event: cyc=%0d got st=%0d en=%0b we=%0b clr=%0b dp=%0b fare=%h/%h/%h, required no change",
                 cyc, s.st, s.en, s.we, s.clr, s.dp, s.sf, s.df, s.wf);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.s != s) begin
          $display("FAIL event: got cyc=%0d st=%0d en=%0b we=%0b clr=%0b dp=%0b fare=%h/%h/%h, required cyc=%0d st=%0d en=%0b we=%0b clr=%0b dp=%0b fare=%h/%h/%h",
                   cyc, s.st, s.en, s.we, s.clr, s.dp, s.sf, s.df, s.wf,
                   e.cyc, e.s.st, e.s.en, e.s.we, e.s.clr, e.s.dp, e.s.sf, e.s.df, e.s.wf);
        end else begin
          n_pass++;
          $display("ev cyc=%0d st=%0d en=%0b we=%0b clr=%0b dp=%0b fare=%h/%h/%h ok",
                   cyc, s.st, s.en, s.we, s.clr, s.dp, s.sf, s.df, s.wf);
        end
      end
    end
    mon_first = 1'b0;
    mon_prev  = s;
  end

  // ---------------- scenario ----------------
  initial begin
    int seg_left;
    bit seg_active;
    rst = 1'b1;
    start_btn = 1'b0; stop_btn = 1'b0; pay_done = 1'b0;
    night_mode = 1'b0; ten_meter_pulse = 1'b0;
    raw_lvl = 1'b0; night_lvl = 1'b0; sync_fired = 1'b0;
    m_phase = P_IDLE; m_last_act = 0; m_raw_prev = 1'b0;
    load_tariff(1'b0);
    seen = mk(P_IDLE, 1'b0, 1'b0);
    @(posedge clk); #2;
    exp_q.push_back('{cyc, seen});
    seen_prev = seen;
    repeat (2) begin @(posedge clk); #2; seen_prev = seen; end

    // Day trip start: HIRED, en, one-cycle meter_clr, day tariff.
    repeat (3) tick(0, 0, 0);
    tick(1, 0, 0);
    // Pulses every 5 cycles keep the trip out of waiting.
    for (int i = 0; i < 60; i++) begin
      if (i % 5 == 0) raw_lvl = 1'b1;
      if (i % 5 == 2) raw_lvl = 1'b0;
      tick(0, 0, 0);
    end
    // Quiet road: timeout into WAITING, then one pulse back to HIRED.
    raw_lvl = 1'b0;
    repeat (20) tick(0, 0, 0);
    raw_lvl = 1'b1;
    repeat (6) tick(0, 0, 0);
    raw_lvl = 1'b0;
    repeat (3) tick(0, 0, 0);
    // stop_btn coinciding with a distance pulse.
    raw_lvl = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(0, 0, 0, 1'b1);
      if (sync_fired) break;
    end
    raw_lvl = 1'b0;
    repeat (2) tick(0, 0, 0);
    tick(1, 0, 0);              // ignored in SETTLE
    repeat (3) tick(0, 0, 0);
    tick(0, 0, 1);              // pay_done -> IDLE
    repeat (3) tick(0, 0, 0);

    // Night trip with night_mode dropped mid-trip.
    night_lvl = 1'b1;
    tick(1, 0, 0);
    for (int i = 0; i < 30; i++) begin
      if (i == 12) night_lvl = 1'b0;
      raw_lvl = (i % 4 < 2);
      tick(0, 0, 0);
    end
    raw_lvl = 1'b0;
    repeat (15) tick(0, 0, 0);
    tick(0, 1, 0);
    repeat (2) tick(0, 0, 0);
    tick(0, 0, 1);
    repeat (2) tick(0, 0, 0);

    // Reset while WAITING on a night trip, then a fresh day trip.
    night_lvl = 1'b1;
    tick(1, 0, 0);
    repeat (14) tick(0, 0, 0);
    do_reset(2);
    night_lvl = 1'b0;
    repeat (2) tick(0, 0, 0);
    tick(1, 0, 0);
    repeat (4) tick(0, 0, 0);

    // Randomised traffic with occasional resets.
    seg_left = 0;
    seg_active = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (seg_left == 0) begin
        seg_active = 1'($urandom_range(0, 1));
        seg_left = int'($urandom_range(4, 30));
      end
      seg_left--;
      if (seg_active && $urandom_range(0, 2) == 0) raw_lvl = ~raw_lvl;
      if ($urandom_range(0, 19) == 0) night_lvl = ~night_lvl;
      if ($urandom_range(0, 399) == 0) begin
        do_reset(int'($urandom_range(1, 3)));
      end else begin
        tick($urandom_range(0, 19) == 0, $urandom_range(0, 39) == 0,
             $urandom_range(0, 9) == 0);
      end
    end

    raw_lvl = 1'b0;
    repeat (12) tick(0, 0, 0);
    @(negedge clk); #1;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL pending_events: got %0d unobserved, required 0 (next cyc=%0d)",
                  exp_q.size(), exp_q[0].cyc);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
